// File: rtl/intersection_controller.sv
// -----------------------------------------------------------------------------
// intersection_controller
//
// Two-way traffic intersection with a pedestrian phase. North-south and
// east-west greens alternate through yellow and an all-red clearance; a
// latched pedestrian request inserts a walk phase after the next all-red.
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous reset, active low
//   ns_req, ew_req               level-sensitive vehicle demand per direction
//   ped_req                      pedestrian button (any high cycle latches)
//   ns_red/ns_yellow/ns_green    north-south lamp drives (registered)
//   ew_red/ew_yellow/ew_green    east-west lamp drives (registered)
//   walk                         pedestrian walk lamp (registered)
//   ped_pending                  latched, not yet served pedestrian request
//   state_o                      current state encoding for debug
// -----------------------------------------------------------------------------
module intersection_controller #(
    parameter int T_GREEN_MIN = 5,
    parameter int T_GREEN_MAX = 12,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    // Last timer value of each timed phase (timer starts at 0 on entry).
    localparam logic [7:0] GREEN_MIN_LAST = 8'(T_GREEN_MIN - 1);
    localparam logic [7:0] GREEN_MAX_LAST = 8'(T_GREEN_MAX - 1);
    localparam logic [7:0] YELLOW_LAST    = 8'(T_YELLOW - 1);
    localparam logic [7:0] ALLRED_LAST    = 8'(T_ALLRED - 1);
    localparam logic [7:0] WALK_LAST      = 8'(T_WALK - 1);

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
    function automatic logic [6:0] lamp_decode(input state_t s);
        logic [6:0] l;
        case (s)
            NS_GREEN:  l = 7'b0011000;
            NS_YELLOW: l = 7'b0101000;
            EW_GREEN:  l = 7'b1000010;
            EW_YELLOW: l = 7'b1000100;
            PED_WALK:  l = 7'b1001001;
            default:   l = 7'b1001000;
        endcase
        return l;
    endfunction

    // A green ends only under competing demand: early once the minimum is
    // served and its own traffic has gone, or unconditionally at the maximum.
    function automatic logic green_exit(input logic compete, input logic own,
                                        input logic [7:0] t);
        return compete && (((t >= GREEN_MIN_LAST) && !own) || (t == GREEN_MAX_LAST));
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] timer_r;
    logic [7:0] timer_next_s;
    logic       timer_hold_s;
    logic       dir_r;
    logic       dir_next_s;
    logic       ped_pending_r;
    logic       ped_pending_next_s;
    logic [6:0] lamps_r;

    // Next-state selection; dir remembers which all-red led into the walk.
    always_comb begin
        state_next_s = state_r;
        dir_next_s   = dir_r;
        timer_hold_s = 1'b0;
        case (state_r)
            NS_GREEN: begin
                if (green_exit(ew_req | ped_pending_r, ns_req, timer_r)) begin
                    state_next_s = NS_YELLOW;
                end else begin
                    timer_hold_s = (timer_r == GREEN_MAX_LAST);
                end
            end
            NS_YELLOW: begin
                if (timer_r == YELLOW_LAST) begin
                    state_next_s = ALLRED_A;
                end else begin
                    state_next_s = state_r;
                end
            end
            ALLRED_A: begin
                if (timer_r == ALLRED_LAST) begin
                    if (ped_pending_r) begin
                        state_next_s = PED_WALK;
                        dir_next_s   = 1'b0;
                    end else begin
                        state_next_s = EW_GREEN;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            EW_GREEN: begin
                if (green_exit(ns_req | ped_pending_r, ew_req, timer_r)) begin
                    state_next_s = EW_YELLOW;
                end else begin
                    timer_hold_s = (timer_r == GREEN_MAX_LAST);
                end
            end
            EW_YELLOW: begin
                if (timer_r == YELLOW_LAST) begin
                    state_next_s = ALLRED_B;
                end else begin
                    state_next_s = state_r;
                end
            end
            ALLRED_B: begin
                if (timer_r == ALLRED_LAST) begin
                    if (ped_pending_r) begin
                        state_next_s = PED_WALK;
                        dir_next_s   = 1'b1;
                    end else begin
                        state_next_s = NS_GREEN;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            PED_WALK: begin
                if (timer_r == WALK_LAST) begin
                    state_next_s = dir_r ? NS_GREEN : EW_GREEN;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ALLRED_B;
            end
        endcase
    end

    // Phase timer and pedestrian latch updates.
    always_comb begin
        timer_next_s       = 8'd0;
        ped_pending_next_s = ped_pending_r;
        if (state_next_s != state_r) begin
            timer_next_s = 8'd0;
        end else if (timer_hold_s) begin
            timer_next_s = timer_r;
        end else begin
            timer_next_s = timer_r + 8'd1;
        end
        // Entering the walk serves the request; a press on the first walk
        // cycle is absorbed, later presses queue another walk.
        if ((state_next_s == PED_WALK) && (state_r != PED_WALK)) begin
            ped_pending_next_s = 1'b0;
        end else if ((state_r == PED_WALK) && (timer_r == 8'd0)) begin
            ped_pending_next_s = ped_pending_r;
        end else if (ped_req) begin
            ped_pending_next_s = 1'b1;
        end else begin
            ped_pending_next_s = ped_pending_r;
        end
    end

    // State, timer, latch and registered lamp decode of the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ALLRED_B;
            timer_r       <= 8'd0;
            dir_r         <= 1'b0;
            ped_pending_r <= 1'b0;
            lamps_r       <= lamp_decode(ALLRED_B);
        end else begin
            state_r       <= state_next_s;
            timer_r       <= timer_next_s;
            dir_r         <= dir_next_s;
            ped_pending_r <= ped_pending_next_s;
            lamps_r       <= lamp_decode(state_next_s);
        end
    end

    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} = lamps_r;
    assign ped_pending = ped_pending_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_intersection_controller.sv
// -----------------------------------------------------------------------------
// tb_intersection_controller
//
// Directed scenarios with hand-computed lamp expectations, then a long
// randomized run. A phase/age model of the intersection predicts the lamps
// and pending flag for every cycle.
// -----------------------------------------------------------------------------
module tb_intersection_controller;

    localparam int GMIN = 5;
    localparam int GMAX = 12;
    localparam int TYEL = 3;
    localparam int TAR  = 1;
    localparam int TWLK = 4;

    // Model phases
    localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4, P_ARB = 5, P_WLK = 6;

    // Lamp patterns {ns r,y,g, ew r,y,g, walk}
    localparam logic [6:0] L_NSG = 7'b0011000;
    localparam logic [6:0] L_NSY = 7'b0101000;
    localparam logic [6:0] L_AR  = 7'b1001000;
    localparam logic [6:0] L_EWG = 7'b1000010;
    localparam logic [6:0] L_EWY = 7'b1000100;
    localparam logic [6:0] L_WLK = 7'b1001001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    intersection_controller #(
        .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX), .T_YELLOW(TYEL),
        .T_ALLRED(TAR), .T_WALK(TWLK)
    ) dut (
        .clk(clk), .rst(rst), .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_pending(ped_pending), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_phase = P_ARB;
    int m_age   = 0;   // cycles spent in the phase, never saturated
    bit m_pend  = 1'b0;
    bit m_from_b = 1'b0;
    bit m_valid = 1'b0;

    function automatic logic [6:0] lamps_of(input int ph);
        case (ph)
            P_NSG:   return L_NSG;
            P_NSY:   return L_NSY;
            P_EWG:   return L_EWG;
            P_EWY:   return L_EWY;
            P_WLK:   return L_WLK;
            default: return L_AR;
        endcase
    endfunction

    function automatic int next_phase(input int ph, input int age, input bit nsr, input bit ewr,
                                      input bit pend, input bit from_b);
        bit done;
        case (ph)
            P_NSG: return ((ewr || pend) && ((age >= GMIN - 1 && !nsr) || age >= GMAX - 1)) ? P_EWG - 2 : P_NSG;
            P_EWG: return ((nsr || pend) && ((age >= GMIN - 1 && !ewr) || age >= GMAX - 1)) ? P_EWY : P_EWG;
            P_NSY: begin done = (age + 1 >= TYEL); return done ? P_ARA : P_NSY; end
            P_EWY: begin done = (age + 1 >= TYEL); return done ? P_ARB : P_EWY; end
            P_ARA: begin done = (age + 1 >= TAR); return done ? (pend ? P_WLK : P_EWG) : P_ARA; end
            P_ARB: begin done = (age + 1 >= TAR); return done ? (pend ? P_WLK : P_NSG) : P_ARB; end
            P_WLK: begin done = (age + 1 >= TWLK); return done ? (from_b ? P_NSG : P_EWG) : P_WLK; end
            default: return P_ARB;
        endcase
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        int nf;
        if (!rst) begin
            m_phase  <= P_ARB;
            m_age    <= 0;
            m_pend   <= 1'b0;
            m_from_b <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            nf = next_phase(m_phase, m_age, ns_req, ew_req, m_pend, m_from_b);
            m_phase <= nf;
            m_age   <= (nf != m_phase) ? 0 : m_age + 1;
            if (nf == P_WLK && m_phase != P_WLK) begin
                m_pend   <= 1'b0;
                m_from_b <= (m_phase == P_ARB);
            end else if (!(m_phase == P_WLK && m_age == 0) && ped_req) begin
                m_pend <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int cyc = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t cyc=%0d got=%b want=%b", name, $time, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending};
    endfunction

    // Advance to the next falling edge and compare against the model.
    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            chk("model", dut_vec(), {lamps_of(m_phase), m_pend});
            chk("lamp_rules",
                {5'd0, ns_green & ew_green,
                 $onehot({ns_red, ns_yellow, ns_green}), $onehot({ew_red, ew_yellow, ew_green})},
                8'b0000_0011);
        end
    endtask

    task automatic drive(input int id, input int c);
        rst     = 1'b1;
        ped_req = 1'b0;
        case (id)
            1: begin ns_req = 1'b0; ew_req = 1'b1; end
            2: begin ns_req = 1'b1; ew_req = 1'b1; end
            3: begin ns_req = 1'b0; ew_req = 1'b0; ped_req = (c == 2); end
            4: begin ns_req = (c < 7); ew_req = 1'b1; end
            5: begin
                ns_req  = (c < 31);
                ew_req  = (c < 31);
                ped_req = (c == 29 || c == 30);
                rst     = (c != 30);
            end
            default: begin ns_req = 1'b0; ew_req = 1'b0; end
        endcase
    endtask

    // Hand-computed expectations, cycle 0 = first cycle after release.
    task automatic lit(input int id, input int c);
        bit en;
        logic [7:0] e;
        en = 1'b1;
        e  = 8'd0;
        case (id)
            0: case (c)
                0:         e = {L_AR, 1'b0};
                1, 20, 40: e = {L_NSG, 1'b0};
                default:   en = 1'b0;
            endcase
            1: case (c)
                5:       e = {L_NSG, 1'b0};
                6, 8:    e = {L_NSY, 1'b0};
                9:       e = {L_AR, 1'b0};
                10, 20:  e = {L_EWG, 1'b0};
                default: en = 1'b0;
            endcase
            2: case (c)
                12, 33:  e = {L_NSG, 1'b0};
                13, 15:  e = {L_NSY, 1'b0};
                16, 32:  e = {L_AR, 1'b0};
                17, 28:  e = {L_EWG, 1'b0};
                29, 31:  e = {L_EWY, 1'b0};
                default: en = 1'b0;
            endcase
            3: case (c)
                2:       e = {L_NSG, 1'b0};
                3, 5:    e = {L_NSG, 1'b1};
                6:       e = {L_NSY, 1'b1};
                9:       e = {L_AR, 1'b1};
                10, 13:  e = {L_WLK, 1'b0};
                14:      e = {L_EWG, 1'b0};
                default: en = 1'b0;
            endcase
            4: case (c)
                6, 7:    e = {L_NSG, 1'b0};
                8, 10:   e = {L_NSY, 1'b0};
                11:      e = {L_AR, 1'b0};
                12:      e = {L_EWG, 1'b0};
                default: en = 1'b0;
            endcase
            5: case (c)
                29:      e = {L_EWY, 1'b0};
                30:      e = {L_EWY, 1'b1};
                31:      e = {L_AR, 1'b0};
                32, 40:  e = {L_NSG, 1'b0};
                default: en = 1'b0;
            endcase
            default: en = 1'b0;
        endcase
        if (en) begin
            chk($sformatf("lit_s%0d_c%0d", id, c), dut_vec(), e);
        end
    endtask

    task automatic run_scenario(input int id, input int ncyc);
        rst = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            cyc = c;
            drive(id, c);
            lit(id, c);
        end
    endtask

    initial begin
        run_scenario(0, 41);
        run_scenario(1, 21);
        run_scenario(2, 34);
        run_scenario(3, 20);
        run_scenario(4, 13);
        run_scenario(5, 41);

        // Randomized traffic, button presses and occasional resets.
        rst = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            cyc = i;
            if ($urandom_range(0, 7) == 0) ns_req = ~ns_req;
            if ($urandom_range(0, 7) == 0) ew_req = ~ew_req;
            ped_req = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 399) != 0);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
